sc_io_ports: RTL and testbench

Parametrised memory-mapped I/O unit for the single-cycle computer. It sits beside the data memory on the CPU's load/store path and generalises the fixed three-output/two-input port set. It adds N_OUT output registers, N_IN input channels with 2-flop synchronisation, a change-detect status register with write-1-to-clear semantics, and a maskable interrupt. The data-memory read mux selects `rdata` whenever `io_sel` is high.

---
 rtl/sc_io_ports_pkg.sv | 24 ++
 rtl/sc_io_ports_if.sv | 16 +
 rtl/sc_io_ports_sync.sv | 27 ++
 rtl/sc_io_ports.sv | 109 ++++++++++
 tb/tb_sc_io_ports.sv | 162 ++++++++++++++++
 5 files changed

// File: rtl/sc_io_ports_pkg.sv
// Shared offsets and address-decode helpers for the memory-mapped I/O unit.
package sc_io_pkg;

  function automatic int status_off(input int n_out, input int n_in);
    return n_out + n_in;
  endfunction

  function automatic int irqen_off(input int n_out, input int n_in);
    return n_out + n_in + 1;
  endfunction

  // Window hit: everything above the word-offset field must match the base.
  function automatic logic io_hit(input logic [63:0] a, input logic [63:0] base,
                                  input int win_w);
    return (a >> (win_w + 2)) == (base >> (win_w + 2));
  endfunction

  function automatic logic [31:0] io_offset(input logic [63:0] a, input int win_w);
    logic [63:0] m;
    m = (a >> 2) & ((64'd1 << win_w) - 64'd1);
    return m[31:0];
  endfunction

endpackage

// File: rtl/sc_io_ports_if.sv
// CPU load/store path as seen by the I/O unit.
interface sc_io_ports_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              we;
  logic              re;
  logic              io_sel;
  logic [DATA_W-1:0] rdata;
  logic              rvalid;

  modport master (output addr, wdata, we, re, input io_sel, rdata, rvalid);
  modport slave  (input addr, wdata, we, re, output io_sel, rdata, rvalid);
endinterface

// File: rtl/sc_io_ports_sync.sv
// Two-flop synchroniser for one input channel; changed is high while the
// second stage is about to take a new value.
module sc_io_sync #(
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q,
  output logic              changed
);
  logic [DATA_W-1:0] r_s1;
  logic [DATA_W-1:0] r_s2;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= d;
      r_s2 <= r_s1;
    end
  end

  assign q       = r_s2;
  assign changed = (r_s1 != r_s2);
endmodule

// File: rtl/sc_io_ports.sv
// Memory-mapped I/O unit: output registers, synchronised inputs, W1C change
// status and a maskable, registered interrupt.
module sc_io_ports
  import sc_io_pkg::*;
#(
  parameter int                DATA_W  = 32,
  parameter int                ADDR_W  = 32,
  parameter int                N_OUT   = 3,
  parameter int                N_IN    = 2,
  parameter logic [ADDR_W-1:0] IO_BASE = 32'h0000_0080,
  parameter int                WIN_W   = 5
) (
  input  logic                    clock,
  input  logic                    reset,
  sc_io_ports_if.slave            bus,
  output logic [N_OUT*DATA_W-1:0] op,
  input  logic [N_IN*DATA_W-1:0]  ip,
  output logic                    irq
);
  localparam logic [31:0] ST_OFF = 32'(status_off(N_OUT, N_IN));
  localparam logic [31:0] IE_OFF = 32'(irqen_off(N_OUT, N_IN));

  logic [DATA_W-1:0] r_out [N_OUT];
  logic [DATA_W-1:0] w_in  [N_IN];
  logic [N_IN-1:0]   w_changed;
  logic [N_IN-1:0]   r_status;
  logic [N_IN-1:0]   r_irqen;
  logic [N_IN-1:0]   w_status_next;
  logic [N_IN-1:0]   w_irqen_next;
  logic [DATA_W-1:0] r_rdata;
  logic              r_rvalid;
  logic              r_irq;
  logic [DATA_W-1:0] w_rmux;
  logic [31:0]       w_off;
  logic              w_sel;
  logic              w_wr;
  logic              w_rd;

  assign w_sel = io_hit(64'(bus.addr), 64'(IO_BASE), WIN_W);
  assign w_off = io_offset(64'(bus.addr), WIN_W);
  assign w_wr  = bus.we & w_sel;
  assign w_rd  = bus.re & w_sel;

  assign bus.io_sel = w_sel;
  assign bus.rdata  = r_rdata;
  assign bus.rvalid = r_rvalid;
  assign irq        = r_irq;

  genvar gi;
  generate
    for (gi = 0; gi < N_OUT; gi++) begin : g_out
      always_ff @(posedge clock) begin
        if (reset)
          r_out[gi] <= '0;
        else if (w_wr && w_off == 32'(gi))
          r_out[gi] <= bus.wdata;
      end
      assign op[gi*DATA_W +: DATA_W] = r_out[gi];
    end

    for (gi = 0; gi < N_IN; gi++) begin : g_in
      sc_io_sync #(.DATA_W(DATA_W)) u_sync (
        .clock   (clock),
        .reset   (reset),
        .d       (ip[gi*DATA_W +: DATA_W]),
        .q       (w_in[gi]),
        .changed (w_changed[gi])
      );
    end
  endgenerate

  // A new change flag beats a same-edge write-1-to-clear.
  always_comb begin
    w_status_next = r_status;
    w_irqen_next  = r_irqen;
    if (w_wr && w_off == ST_OFF)
      w_status_next = r_status & ~bus.wdata[N_IN-1:0];
    w_status_next = w_status_next | w_changed;
    if (w_wr && w_off == IE_OFF)
      w_irqen_next = bus.wdata[N_IN-1:0];
  end

  always_comb begin
    w_rmux = '0;
    for (int k = 0; k < N_OUT; k++)
      if (w_off == 32'(k)) w_rmux = r_out[k];
    for (int k = 0; k < N_IN; k++)
      if (w_off == 32'(N_OUT + k)) w_rmux = w_in[k];
    if (w_off == ST_OFF) w_rmux = DATA_W'(r_status);
    if (w_off == IE_OFF) w_rmux = DATA_W'(r_irqen);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_status <= '0;
      r_irqen  <= '0;
      r_irq    <= 1'b0;
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
    end else begin
      r_status <= w_status_next;
      r_irqen  <= w_irqen_next;
      r_irq    <= |(w_status_next & w_irqen_next);
      r_rvalid <= w_rd;
      // Mux sees pre-edge state, so a same-cycle write is not reflected.
      if (w_rd) r_rdata <= w_rmux;
    end
  end
endmodule

// File: tb/tb_sc_io_ports.sv
// Directed bench for sc_io_ports: one line per bus transaction, summary at end.
module tb_sc_io_ports;
  logic        clock = 1'b0;
  logic        reset;
  logic [95:0] op;
  logic [63:0] ip;
  logic        irq;
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] rd;

  sc_io_ports_if #(.DATA_W(32), .ADDR_W(32)) bus ();

  sc_io_ports #(
    .DATA_W(32), .ADDR_W(32), .N_OUT(3), .N_IN(2),
    .IO_BASE(32'h0000_0080), .WIN_W(5)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave),
    .op    (op),
    .ip    (ip),
    .irq   (irq)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One bus cycle; outputs are observed 1 time unit after the edge.
  task automatic cycle(input logic [31:0] a, input logic [31:0] d, input logic w, input logic r);
    bus.addr  = a;
    bus.wdata = d;
    bus.we    = w;
    bus.re    = r;
    @(posedge clock);
    #1;
    $display("cycle addr=%h wdata=%h we=%0b re=%0b -> rvalid=%0b rdata=%h irq=%0b",
             a, d, w, r, bus.rvalid, bus.rdata, irq);
    bus.we = 1'b0;
    bus.re = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    cycle(a, d, 1'b1, 1'b0);
  endtask

  task automatic rdchk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    cycle(a, 32'h0, 1'b0, 1'b1);
    check({tag, "_rvalid"}, 32'(bus.rvalid), 32'd1);
    check(tag, bus.rdata, exp);
  endtask

  task automatic idle();
    cycle(32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  initial begin
    reset     = 1'b1;
    ip        = '0;
    bus.addr  = '0;
    bus.wdata = '0;
    bus.we    = 1'b0;
    bus.re    = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_op0", op[31:0], 32'h0);
    check("rst_op2", op[95:64], 32'h0);
    check("rst_rvalid", 32'(bus.rvalid), 32'd0);
    check("rst_rdata", bus.rdata, 32'h0);
    check("rst_irq", 32'(irq), 32'd0);
    reset = 1'b0;

    wr(32'h80, 32'hDEAD_BEEF);
    check("op0", op[31:0], 32'hDEAD_BEEF);
    wr(32'h84, 32'h1234_5678);
    check("op1", op[63:32], 32'h1234_5678);
    wr(32'h88, 32'hFFFF_0000);
    check("op2", op[95:64], 32'hFFFF_0000);
    check("op0_kept", op[31:0], 32'hDEAD_BEEF);
    rdchk("rd_out1", 32'h84, 32'h1234_5678);
    idle();
    check("rvalid_pulse", 32'(bus.rvalid), 32'd0);
    check("rdata_hold", bus.rdata, 32'h1234_5678);

    // Input latency: reads at the first two edges still see the old value.
    ip[31:0] = 32'h0000_00A5;
    rdchk("in0_lat0", 32'h8C, 32'h0);
    rdchk("in0_lat1", 32'h8C, 32'h0);
    rdchk("in0_new", 32'h8C, 32'hA5);
    rdchk("status_in0", 32'h94, 32'h1);
    check("irq_masked", 32'(irq), 32'd0);

    wr(32'h94, 32'h1);
    rdchk("status_clr0", 32'h94, 32'h0);
    wr(32'h98, 32'h3);
    check("irq_en_idle", 32'(irq), 32'd0);
    ip[63:32] = 32'h0000_0001;
    idle();
    check("irq_after1", 32'(irq), 32'd0);
    idle();
    check("irq_after2", 32'(irq), 32'd1);
    wr(32'h94, 32'h2);
    check("irq_cleared", 32'(irq), 32'd0);
    rdchk("status_zero", 32'h94, 32'h0);

    // Clear lands on the edge where the new ip0 value reaches stage two.
    ip[31:0] = 32'h0000_005A;
    idle();
    wr(32'h94, 32'h1);
    check("irq_setwins", 32'(irq), 32'd1);
    rdchk("status_setwins", 32'h94, 32'h1);
    wr(32'h94, 32'h1);
    check("irq_clr_again", 32'(irq), 32'd0);

    cycle(32'h80, 32'h1111_1111, 1'b1, 1'b1);
    check("rw_same_rdata", bus.rdata, 32'hDEAD_BEEF);
    check("rw_same_op0", op[31:0], 32'h1111_1111);

    wr(32'h8C, 32'hFFFF_FFFF);
    rdchk("in0_ro", 32'h8C, 32'h5A);
    wr(32'h98, 32'hFFFF_FFFF);
    rdchk("irqen_mask", 32'h98, 32'h3);

    bus.addr = 32'h100;
    #1;
    check("iosel_out", 32'(bus.io_sel), 32'd0);
    wr(32'h100, 32'hCAFE_F00D);
    check("oow_op0", op[31:0], 32'h1111_1111);
    check("oow_op1", op[63:32], 32'h1234_5678);
    check("oow_op2", op[95:64], 32'hFFFF_0000);
    cycle(32'h100, 32'h0, 1'b0, 1'b1);
    check("oow_rvalid", 32'(bus.rvalid), 32'd0);
    bus.addr = 32'h9C;
    #1;
    check("iosel_in", 32'(bus.io_sel), 32'd1);
    rdchk("unmapped", 32'h9C, 32'h0);

    bus.addr = 32'h84;
    bus.re   = 1'b1;
    reset    = 1'b1;
    @(posedge clock);
    #1;
    $display("cycle addr=00000084 re=1 reset=1 -> rvalid=%0b rdata=%h", bus.rvalid, bus.rdata);
    bus.re = 1'b0;
    check("rst_mid_rvalid", 32'(bus.rvalid), 32'd0);
    check("rst_mid_op0", op[31:0], 32'h0);
    check("rst_mid_op1", op[63:32], 32'h0);
    check("rst_mid_op2", op[95:64], 32'h0);
    check("rst_mid_irq", 32'(irq), 32'd0);
    reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
